// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the multi-cycle control unit: FSM states,
//               RV32I opcodes, ALU operation codes, immediate-generator
//               selects and branch funct3 values.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // FSM state encoding (visible on state_o for debug)
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Immediate generator selects (2'b11 is reserved and never produced)
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Memory and branch funct3 values
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Immediate format chosen purely by opcode
  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      default:   return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational map from (opcode, funct3, funct7[5]) to the ALU
//               operation code and an instruction-legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] aluop_o,
  output logic       legal_o
);

  logic w_is_r;
  assign w_is_r = (opcode_i == OP_R);

  // Operation and legality decode; bit 30 only matters for SUB/SRA/SRAI/SLLI
  always_comb begin
    aluop_o = ALU_ADD;
    legal_o = 1'b0;
    case (opcode_i)
      OP_R, OP_I: begin
        case (funct3_i)
          3'b000:  aluop_o = (w_is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  aluop_o = ALU_SLL;
          3'b010:  aluop_o = ALU_SLT;
          3'b011:  aluop_o = ALU_SLTU;
          3'b100:  aluop_o = ALU_XOR;
          3'b101:  aluop_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  aluop_o = ALU_OR;
          default: aluop_o = ALU_AND;
        endcase
        if (w_is_r)
          legal_o = !funct7b5_i || (funct3_i == 3'b000) || (funct3_i == 3'b101);
        else
          legal_o = !((funct3_i == 3'b001) && funct7b5_i);
      end
      OP_LOAD: begin
        aluop_o = ALU_ADD;
        legal_o = (funct3_i == F3_LW);
      end
      OP_STORE: begin
        aluop_o = ALU_ADD;
        legal_o = (funct3_i == F3_SW);
      end
      OP_BRANCH: begin
        aluop_o = ALU_SUB;
        legal_o = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE) ||
                  (funct3_i == F3_BLT) || (funct3_i == F3_BGE);
      end
      default: begin
        aluop_o = ALU_ADD;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle control unit for an RV32I subset (R/I ALU, LW, SW,
//               BEQ/BNE/BLT/BGE). Latches the instruction in FETCH, walks it
//               through DECODE/EXECUTE/MEMORY/WRITEBACK and drives the
//               datapath controls from (state, IR, status) only.
//               Optional macro PERF_INSTRET_EN enables the retired-instruction
//               counter; without it instret is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int STATUS_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [XLEN-1:0]     instr,
  input  logic [STATUS_W-1:0] status,
  output logic                pc_we,
  output logic                pcsrc,
  output logic                alusrc,
  output logic [3:0]          aluop,
  output logic                mrw,
  output logic                wb,
  output logic                regrw,
  output logic [1:0]          immgen_ctrl,
  output logic [2:0]          state_o,
  output logic                illegal,
  output logic [XLEN-1:0]     instret
);

  state_e          state_q;
  logic [XLEN-1:0] ir_q;
  logic            illegal_q;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [3:0] w_dec_aluop;
  logic       w_dec_legal;
  logic       w_f7_checked;
  logic       w_f7_rest_ok;
  logic       w_legal;
  logic       w_is_r, w_is_load, w_is_store, w_is_branch;
  logic       w_taken;

  assign w_opcode    = ir_q[6:0];
  assign w_funct3    = ir_q[14:12];
  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);

  alu_decoder u_alu_decoder (
    .opcode_i   (w_opcode),
    .funct3_i   (w_funct3),
    .funct7b5_i (ir_q[30]),
    .aluop_o    (w_dec_aluop),
    .legal_o    (w_dec_legal)
  );

  // R-type and shift-immediates also need the remaining funct7 bits clear
  assign w_f7_checked = w_is_r ||
                        ((w_opcode == OP_I) && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)));
  assign w_f7_rest_ok = !ir_q[31] && (ir_q[29:25] == 5'b00000);
  assign w_legal      = w_dec_legal && (!w_f7_checked || w_f7_rest_ok);

  // Branch resolution from {V,C,N,Z}
  always_comb begin
    case (w_funct3)
      F3_BEQ:  w_taken = status[0];
      F3_BNE:  w_taken = !status[0];
      F3_BLT:  w_taken = status[1] ^ status[3];
      default: w_taken = !(status[1] ^ status[3]);
    endcase
  end

  // State sequencing, instruction latch and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (run) begin
            ir_q    <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            state_q <= ST_EXECUTE;
          end else begin
            state_q   <= ST_HALT;
            illegal_q <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (w_is_branch)                  state_q <= ST_FETCH;
          else if (w_is_load || w_is_store) state_q <= ST_MEMORY;
          else                              state_q <= ST_WRITEBACK;
        end
        ST_MEMORY:    state_q <= w_is_store ? ST_FETCH : ST_WRITEBACK;
        ST_WRITEBACK: state_q <= ST_FETCH;
        ST_HALT:      state_q <= ST_HALT;
        default:      state_q <= ST_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state and latched IR
  always_comb begin
    pc_we       = 1'b0;
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    aluop       = ALU_ADD;
    mrw         = 1'b0;
    wb          = 1'b0;
    regrw       = 1'b0;
    immgen_ctrl = IMM_I;
    case (state_q)
      ST_DECODE: begin
        immgen_ctrl = imm_sel(w_opcode);
      end
      ST_EXECUTE: begin
        immgen_ctrl = imm_sel(w_opcode);
        alusrc      = !(w_is_r || w_is_branch);
        aluop       = w_dec_aluop;
        if (w_is_branch) begin
          pc_we = 1'b1;
          pcsrc = w_taken;
        end
      end
      ST_MEMORY: begin
        immgen_ctrl = imm_sel(w_opcode);
        alusrc      = 1'b1;
        aluop       = ALU_ADD;
        if (w_is_store) begin
          mrw   = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        immgen_ctrl = imm_sel(w_opcode);
        alusrc      = !w_is_r;
        aluop       = w_dec_aluop;
        regrw       = 1'b1;
        pc_we       = 1'b1;
        wb          = !w_is_load;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign illegal = illegal_q;

`ifdef PERF_INSTRET_EN
  localparam logic [XLEN-1:0] c_ONE = {{(XLEN-1){1'b0}}, 1'b1};
  logic [XLEN-1:0] instret_q;

  // Count every cycle in which the PC is loaded (one per retired instruction)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + c_ONE;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
`default_nettype wire
